// File: rtl/lab4_debug_scan_bridge.sv
// lab4_debug_scan_bridge: virtual-JTAG DR/IR scan bridge with scan-length checking and take/no-take pulses
module lab4_debug_scan_bridge #(
    parameter int IR_WIDTH   = 2,
    parameter int DR_WIDTH   = 38,
    parameter int ACTION_BIT = DR_WIDTH - 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                vs_uir,
    input  logic                                vs_cdr,
    input  logic                                vs_sdr,
    input  logic                                vs_udr,
    input  logic                                tdi,
    input  logic [IR_WIDTH-1:0]                 ir_in,
    input  logic [(2**IR_WIDTH)*DR_WIDTH-1:0]   capture_data,
    input  logic                                clear_error,
    output logic                                tdo,
    output logic [IR_WIDTH-1:0]                 ir_out,
    output logic [DR_WIDTH-1:0]                 jdo,
    output logic [(2**IR_WIDTH)-1:0]            take_action,
    output logic [(2**IR_WIDTH)-1:0]            take_no_action,
    output logic                                scan_error
);
    localparam int NUM_IR = 2 ** IR_WIDTH;
    localparam int CW = $clog2(DR_WIDTH + 2);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t              state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d, jdo_q, jdo_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                scan_error_q, scan_error_d;
    logic [NUM_IR-1:0]   ta_q, ta_d, tna_q, tna_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ir_q         <= '0;
            sr_q         <= '0;
            cnt_q        <= '0;
            jdo_q        <= '0;
            scan_error_q <= 1'b0;
            ta_q         <= '0;
            tna_q        <= '0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            jdo_q        <= jdo_d;
            scan_error_q <= scan_error_d;
            ta_q         <= ta_d;
            tna_q        <= tna_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        jdo_d        = jdo_q;
        scan_error_d = scan_error_q & ~clear_error;
        ta_d         = '0;
        tna_d        = '0;
        if (vs_uir) begin
            ir_d    = ir_in;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (vs_cdr) begin
            sr_d    = capture_data[int'(ir_q) * DR_WIDTH +: DR_WIDTH];
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (vs_udr) begin
            if (state_q == SHIFT) begin
                state_d = IDLE;
                if (cnt_q == CW'(DR_WIDTH)) begin
                    jdo_d        = sr_q;
                    ta_d[ir_q]   = sr_q[ACTION_BIT];
                    tna_d[ir_q]  = ~sr_q[ACTION_BIT];
                end else begin
                    scan_error_d = 1'b1;
                end
            end
        end else if (vs_sdr && state_q == SHIFT) begin
            sr_d  = {tdi, sr_q[DR_WIDTH-1:1]};
            cnt_d = (cnt_q == CW'(DR_WIDTH + 1)) ? cnt_q : cnt_q + CW'(1);
        end
    end
    assign tdo            = sr_q[0];
    assign ir_out         = IR_WIDTH'({state_q == SHIFT, scan_error_q});
    assign jdo            = jdo_q;
    assign take_action    = ta_q;
    assign take_no_action = tna_q;
    assign scan_error     = scan_error_q;
endmodule

// File: tb/tb_lab4_debug_scan_bridge.sv
// tb_lab4_debug_scan_bridge: vector table, corner sequences and randomized scans against a word-level model
module tb_lab4_debug_scan_bridge;
    localparam logic [3:0] NONE = 4'b0000, UIR = 4'b1000, CDR = 4'b0100, SDR = 4'b0010, UDR = 4'b0001;
    logic        clk = 1'b0;
    logic        reset, vs_uir, vs_cdr, vs_sdr, vs_udr, tdi, clear_error;
    logic [1:0]  ir_in;
    logic [31:0] capture_data;
    logic        tdo, scan_error;
    logic [1:0]  ir_out;
    logic [7:0]  jdo;
    logic [3:0]  take_action, take_no_action;
    int n_chk = 0, n_fail = 0;

    lab4_debug_scan_bridge #(.IR_WIDTH(2), .DR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
        .vs_udr(vs_udr), .tdi(tdi), .ir_in(ir_in), .capture_data(capture_data),
        .clear_error(clear_error), .tdo(tdo), .ir_out(ir_out), .jdo(jdo),
        .take_action(take_action), .take_no_action(take_no_action), .scan_error(scan_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       t;
        logic       clr;
        logic       e_tdo;
        logic [7:0] e_jdo;
        logic [3:0] e_ta;
        logic [3:0] e_tna;
        logic       e_err;
        logic [1:0] e_irout;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [3:0] st, input logic t, input logic clr, input logic e_tdo,
                                input logic [7:0] e_jdo, input logic [3:0] e_ta, input logic [3:0] e_tna,
                                input logic e_err, input logic [1:0] e_irout);
        tbl.push_back('{st, t, clr, e_tdo, e_jdo, e_ta, e_tna, e_err, e_irout});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_tdo, input logic [7:0] e_jdo, input logic [3:0] e_ta,
                           input logic [3:0] e_tna, input logic e_err, input logic [1:0] e_irout);
        chk({tag, ".tdo"}, 32'(tdo), 32'(e_tdo));
        chk({tag, ".jdo"}, 32'(jdo), 32'(e_jdo));
        chk({tag, ".take_action"}, 32'(take_action), 32'(e_ta));
        chk({tag, ".take_no_action"}, 32'(take_no_action), 32'(e_tna));
        chk({tag, ".scan_error"}, 32'(scan_error), 32'(e_err));
        chk({tag, ".ir_out"}, 32'(ir_out), 32'(e_irout));
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge
    task automatic drive(input logic [3:0] st, input logic t, input logic [1:0] ir, input logic cl, input logic r);
        {vs_uir, vs_cdr, vs_sdr, vs_udr} = st;
        tdi = t; ir_in = ir; clear_error = cl; reset = r;
        @(posedge clk);
        #1;
        {vs_uir, vs_cdr, vs_sdr, vs_udr} = 4'b0;
        tdi = 1'b0; clear_error = 1'b0; reset = 1'b0;
    endtask

    // Behavioural model: captured word as an integer, unbounded shift count
    int m_ir, m_word, m_cnt, m_jdo;
    bit m_scan, m_err;
    int m_ta, m_tna;

    task automatic rstep(input logic [3:0] st, input logic t, input logic [1:0] ir, input logic cl, input logic r);
        m_ta = 0; m_tna = 0;
        if (r) begin
            m_ir = 0; m_word = 0; m_cnt = 0; m_jdo = 0; m_scan = 0; m_err = 0;
        end else begin
            if (cl) m_err = 0;
            if (st[3]) begin
                m_ir = ir; m_scan = 0; m_cnt = 0;
            end else if (st[2]) begin
                m_word = (capture_data >> (m_ir * 8)) & 255; m_cnt = 0; m_scan = 1;
            end else if (st[0]) begin
                if (m_scan) begin
                    m_scan = 0;
                    if (m_cnt == 8) begin
                        m_jdo = m_word;
                        if (m_word >= 128) m_ta = 1 << m_ir; else m_tna = 1 << m_ir;
                    end else m_err = 1;
                end
            end else if (st[1] && m_scan) begin
                m_word = (m_word >> 1) | (int'(t) << 7);
                m_cnt++;
            end
        end
        drive(st, t, ir, cl, r);
        chk_all("rand", 1'(m_word & 1), 8'(m_jdo), 4'(m_ta), 4'(m_tna), m_err, {m_scan, m_err});
    endtask

    task automatic rand_scan();
        int n;
        int pick;
        pick = $urandom_range(0, 9);
        n = (pick < 5) ? 8 : (pick == 5) ? 7 : (pick == 6) ? 9 : $urandom_range(0, 11);
        capture_data = $urandom;
        if ($urandom_range(0, 3) == 0) rstep(UIR, 1'b0, 2'($urandom), 1'b0, 1'b0);
        rstep(CDR | 4'($urandom_range(0, 15) & {4{$urandom_range(0, 7) == 0}}), 1'b0, 2'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 5) == 0) rstep(NONE, 1'($urandom), 2'd0, 1'($urandom_range(0, 9) == 0), 1'b0);
            rstep(SDR, 1'($urandom), 2'd0, 1'b0, $urandom_range(0, 199) == 0);
        end
        rstep(UDR | ({$urandom_range(0, 9) == 0, 3'b000}), 1'b0, 2'($urandom), 1'($urandom_range(0, 7) == 0), 1'b0);
        if ($urandom_range(0, 2) == 0) rstep(NONE, 1'b0, 2'd0, 1'($urandom_range(0, 3) == 0), 1'b0);
    endtask

    initial begin
        {vs_uir, vs_cdr, vs_sdr, vs_udr, tdi, clear_error} = 6'b0;
        ir_in = 2'd0;
        capture_data = {8'h0F, 8'hA5, 8'h5A, 8'h3C};
        reset = 1'b1;
        @(posedge clk);
        drive(NONE, 1'b0, 2'd0, 1'b0, 1'b1);
        chk_all("reset", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 2'b00);
        drive(SDR, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("reset_sdr_ignored.tdo", 32'(tdo), 32'd0);

        add(UIR, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0, 2'b00);
        add(CDR, 0, 0, 1, 8'h00, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 1, 0, 0, 8'h00, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 1, 0, 1, 8'h00, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 1, 0, 1, 8'h00, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 1, 8'h00, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 1, 0, 1, 8'h00, 4'h0, 4'h0, 0, 2'b10);
        add(UDR, 0, 0, 1, 8'h93, 4'h4, 4'h0, 0, 2'b00);
        add(NONE, 0, 0, 1, 8'h93, 4'h0, 4'h0, 0, 2'b00);
        add(CDR, 0, 0, 1, 8'h93, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 1, 0, 0, 8'h93, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 1, 0, 1, 8'h93, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h93, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h93, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 1, 0, 1, 8'h93, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h93, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 1, 8'h93, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 1, 8'h93, 4'h0, 4'h0, 0, 2'b10);
        add(UDR, 0, 0, 1, 8'h13, 4'h0, 4'h4, 0, 2'b00);
        add(NONE, 0, 0, 1, 8'h13, 4'h0, 4'h0, 0, 2'b00);
        add(CDR, 0, 0, 1, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 1, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 1, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 1, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(UDR, 0, 0, 1, 8'h13, 4'h0, 4'h0, 1, 2'b01);
        add(NONE, 0, 1, 1, 8'h13, 4'h0, 4'h0, 0, 2'b00);
        add(CDR, 0, 0, 1, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 1, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 1, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 1, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(SDR, 0, 0, 0, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(UDR, 0, 0, 0, 8'h13, 4'h0, 4'h0, 1, 2'b01);
        add(NONE, 0, 0, 0, 8'h13, 4'h0, 4'h0, 1, 2'b01);
        add(NONE, 0, 1, 0, 8'h13, 4'h0, 4'h0, 0, 2'b00);
        add(CDR, 0, 0, 1, 8'h13, 4'h0, 4'h0, 0, 2'b10);
        add(UDR, 0, 1, 1, 8'h13, 4'h0, 4'h0, 1, 2'b01);
        add(NONE, 0, 1, 1, 8'h13, 4'h0, 4'h0, 0, 2'b00);
        add(UDR, 0, 0, 1, 8'h13, 4'h0, 4'h0, 0, 2'b00);
        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].t, 2'd2, tbl[i].clr, 1'b0);
            chk_all($sformatf("vec%0d", i), tbl[i].e_tdo, tbl[i].e_jdo, tbl[i].e_ta, tbl[i].e_tna,
                    tbl[i].e_err, tbl[i].e_irout);
        end

        // Capture beats a same-cycle update and restarts the count
        drive(CDR, 1'b0, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(SDR, 1'b1, 2'd2, 1'b0, 1'b0);
        drive(CDR | UDR, 1'b0, 2'd2, 1'b0, 1'b0);
        chk_all("cdr_udr", 1'b1, 8'h13, 4'h0, 4'h0, 1'b0, 2'b10);
        for (int i = 0; i < 8; i++) drive(SDR, 1'b0, 2'd2, 1'b0, 1'b0);
        drive(UDR, 1'b0, 2'd2, 1'b0, 1'b0);
        chk_all("cdr_udr_recount", 1'b0, 8'h00, 4'h0, 4'h4, 1'b0, 2'b00);

        // Instruction update beats a same-cycle data update
        drive(CDR, 1'b0, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(SDR, 1'b1, 2'd2, 1'b0, 1'b0);
        drive(UIR | UDR, 1'b0, 2'd1, 1'b0, 1'b0);
        chk_all("uir_udr", 1'b1, 8'h00, 4'h0, 4'h0, 1'b0, 2'b00);
        drive(CDR, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("uir_udr_new_ir.tdo", 32'(tdo), 32'd0);
        for (int i = 0; i < 8; i++) drive(SDR, 1'b1, 2'd0, 1'b0, 1'b0);
        drive(UDR, 1'b0, 2'd0, 1'b0, 1'b0);
        chk_all("ir1_take", 1'b1, 8'hFF, 4'h2, 4'h0, 1'b0, 2'b00);

        // Reset mid-scan abandons the scan
        drive(CDR, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(SDR, 1'b1, 2'd0, 1'b0, 1'b0);
        drive(NONE, 1'b0, 2'd0, 1'b0, 1'b1);
        drive(UDR, 1'b0, 2'd0, 1'b0, 1'b0);
        chk_all("reset_mid_scan", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 2'b00);
        drive(SDR, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("reset_mid_scan_sdr.tdo", 32'(tdo), 32'd0);

        rstep(NONE, 1'b0, 2'd0, 1'b0, 1'b1);
        for (int s = 0; s < 80; s++) rand_scan();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
